// File: rtl/fme_mvd_cost_ctrl.sv
// fme_mvd_cost_ctrl: per-candidate MVD rate cost (lambda * Exp-Golomb bit length)
// with running minimum over a candidate list. Rev 1.0
`default_nettype none

module fme_mvd_cost_ctrl #(
  parameter int MV_WIDTH     = 12,
  parameter int LAMBDA_WIDTH = 8,
  parameter int COST_WIDTH   = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start_i,
  input  logic signed [MV_WIDTH-1:0]     mvp_x_i,
  input  logic signed [MV_WIDTH-1:0]     mvp_y_i,
  input  logic        [LAMBDA_WIDTH-1:0] lambda_i,
  input  logic                           cand_valid_i,
  output logic                           cand_ready_o,
  input  logic signed [MV_WIDTH-1:0]     cand_mv_x_i,
  input  logic signed [MV_WIDTH-1:0]     cand_mv_y_i,
  input  logic                           cand_last_i,
  output logic                           busy_o,
  output logic                           cost_valid_o,
  output logic        [COST_WIDTH-1:0]   cost_o,
  output logic                           done_o,
  output logic signed [MV_WIDTH-1:0]     best_mv_x_o,
  output logic signed [MV_WIDTH-1:0]     best_mv_y_o,
  output logic        [COST_WIDTH-1:0]   best_cost_o
);

  localparam int          PW       = LAMBDA_WIDTH + 6;
  localparam logic [63:0] COST_MAX = (64'd1 << COST_WIDTH) - 64'd1;
  localparam logic [MV_WIDTH:0] ONE = 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAIT   = 3'd1,
    CALC_X = 3'd2,
    CALC_Y = 3'd3,
    COST   = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic signed [MV_WIDTH-1:0]     mvp_x, mvp_y, cand_x, cand_y;
  logic        [LAMBDA_WIDTH-1:0] lambda;
  logic                           cand_last;
  logic        [4:0]              bits_x, bits_y;

  logic signed [MV_WIDTH-1:0] comp_cand, comp_mvp;
  logic        [MV_WIDTH:0]   diff, mag;
  logic        [31:0]         mag32;
  logic        [10:0]         vclamp;
  logic        [4:0]          bl_out;
  logic        [5:0]          bit_sum;
  logic        [PW-1:0]       prod;
  logic        [COST_WIDTH-1:0] cost_sat;
  logic                       better;

  // Saturating odd Exp-Golomb length: 2*msb+3 below 1024, 31 at or above.
  function automatic logic [4:0] bit_len(input logic [10:0] v);
    logic [4:0] bl;
    if (v == 11'd0) begin
      bl = 5'd1;
    end else if (v[10]) begin
      bl = 5'd31;
    end else begin
      bl = 5'd3;
      for (int i = 1; i < 10; i++) begin
        if (v[i]) bl = 5'(2 * i + 3);
      end
    end
    return bl;
  endfunction

  // Single bit-length unit shared by x (CALC_X) and y (CALC_Y).
  always_comb begin
    comp_cand = (state == CALC_Y) ? cand_y : cand_x;
    comp_mvp  = (state == CALC_Y) ? mvp_y  : mvp_x;
    diff      = {comp_cand[MV_WIDTH-1], comp_cand} - {comp_mvp[MV_WIDTH-1], comp_mvp};
    mag       = diff[MV_WIDTH] ? (~diff + ONE) : diff;
    mag32     = 32'(mag);
    vclamp    = (mag32 > 32'd2047) ? 11'd2047 : mag32[10:0];
    bl_out    = bit_len(vclamp);
  end

  always_comb begin
    bit_sum  = {1'b0, bits_x} + {1'b0, bits_y};
    prod     = PW'(lambda) * PW'(bit_sum);
    cost_sat = (64'(prod) > COST_MAX) ? COST_WIDTH'(COST_MAX) : COST_WIDTH'(prod);
    better   = (cost_sat < best_cost_o);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_i) state_nxt = WAIT;
      WAIT:    if (cand_valid_i) state_nxt = CALC_X;
      CALC_X:  state_nxt = CALC_Y;
      CALC_Y:  state_nxt = COST;
      COST:    state_nxt = cand_last ? IDLE : WAIT;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mvp_x        <= '0;
      mvp_y        <= '0;
      lambda       <= '0;
      cand_x       <= '0;
      cand_y       <= '0;
      cand_last    <= 1'b0;
      bits_x       <= '0;
      bits_y       <= '0;
      cand_ready_o <= 1'b0;
      busy_o       <= 1'b0;
      cost_valid_o <= 1'b0;
      cost_o       <= '0;
      done_o       <= 1'b0;
      best_mv_x_o  <= '0;
      best_mv_y_o  <= '0;
      best_cost_o  <= '0;
    end else begin
      cand_ready_o <= (state_nxt == WAIT);
      busy_o       <= (state_nxt != IDLE);
      cost_valid_o <= 1'b0;
      done_o       <= 1'b0;
      case (state)
        IDLE: if (start_i) begin
          mvp_x       <= mvp_x_i;
          mvp_y       <= mvp_y_i;
          lambda      <= lambda_i;
          best_cost_o <= '1;
          best_mv_x_o <= '0;
          best_mv_y_o <= '0;
        end
        WAIT: if (cand_valid_i) begin
          cand_x    <= cand_mv_x_i;
          cand_y    <= cand_mv_y_i;
          cand_last <= cand_last_i;
        end
        CALC_X: bits_x <= bl_out;
        CALC_Y: bits_y <= bl_out;
        COST: begin
          cost_o       <= cost_sat;
          cost_valid_o <= 1'b1;
          // Strict compare: on a tie the earlier candidate stays best.
          if (better) begin
            best_cost_o <= cost_sat;
            best_mv_x_o <= cand_x;
            best_mv_y_o <= cand_y;
          end
          if (cand_last) done_o <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fme_mvd_cost_ctrl.sv
// Self-checking bench for fme_mvd_cost_ctrl with a behavioural cost/minimum model.
`default_nettype none

module tb_fme_mvd_cost_ctrl;

  localparam int MVW = 12;
  localparam int LW  = 8;
  localparam int CW  = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst = 1'b1;
  logic                  start_i = 1'b0;
  logic signed [MVW-1:0] mvp_x_i = '0, mvp_y_i = '0;
  logic        [LW-1:0]  lambda_i = '0;
  logic                  cand_valid_i = 1'b0;
  logic                  cand_ready_o;
  logic signed [MVW-1:0] cand_mv_x_i = '0, cand_mv_y_i = '0;
  logic                  cand_last_i = 1'b0;
  logic                  busy_o, cost_valid_o, done_o;
  logic        [CW-1:0]  cost_o, best_cost_o;
  logic signed [MVW-1:0] best_mv_x_o, best_mv_y_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  fme_mvd_cost_ctrl #(.MV_WIDTH(MVW), .LAMBDA_WIDTH(LW), .COST_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .mvp_x_i(mvp_x_i), .mvp_y_i(mvp_y_i),
    .lambda_i(lambda_i), .cand_valid_i(cand_valid_i), .cand_ready_o(cand_ready_o),
    .cand_mv_x_i(cand_mv_x_i), .cand_mv_y_i(cand_mv_y_i), .cand_last_i(cand_last_i),
    .busy_o(busy_o), .cost_valid_o(cost_valid_o), .cost_o(cost_o), .done_o(done_o),
    .best_mv_x_o(best_mv_x_o), .best_mv_y_o(best_mv_y_o), .best_cost_o(best_cost_o)
  );

  // ---------------- reference model ----------------
  function automatic int ref_bl(input int v);
    int n;
    if (v == 0) return 1;
    if (v >= 1024) return 31;
    n = 0;
    while ((1 << (n + 1)) <= v) n++;
    return 2 * n + 3;
  endfunction

  function automatic int ref_cost(input int lam, input int mx, input int my,
                                  input int cx, input int cy);
    int ax, ay, p;
    ax = (cx - mx < 0) ? (mx - cx) : (cx - mx);
    ay = (cy - my < 0) ? (my - cy) : (cy - my);
    if (ax > 2047) ax = 2047;
    if (ay > 2047) ay = 2047;
    p = lam * (ref_bl(ax) + ref_bl(ay));
    return (p > 65535) ? 65535 : p;
  endfunction

  // ---------------- drivers (return observations; checks live in tests) ----------------
  task automatic do_start(input int mx, input int my, input int lam);
    start_i  = 1'b1;
    mvp_x_i  = MVW'(mx);
    mvp_y_i  = MVW'(my);
    lambda_i = LW'(lam);
    @(posedge clk); #1;
    start_i  = 1'b0;
  endtask

  task automatic send_cand(input int cx, input int cy, input bit last,
                           output bit got_valid, output int cost, output bit got_done,
                           output int bx, output int by, output int bcost,
                           output int pcyc, output bit early, output bit timeout);
    int n;
    early = 1'b0; timeout = 1'b0; got_valid = 1'b0; got_done = 1'b0;
    cost = 0; bx = 0; by = 0; bcost = 0; pcyc = 0;
    cand_valid_i = 1'b1;
    cand_mv_x_i  = MVW'(cx);
    cand_mv_y_i  = MVW'(cy);
    cand_last_i  = last;
    n = 0;
    while (!cand_ready_o && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (!cand_ready_o) begin
      timeout = 1'b1;
      cand_valid_i = 1'b0;
      return;
    end
    @(posedge clk); #1;
    cand_valid_i = 1'b0;
    cand_last_i  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (cost_valid_o || done_o) early = 1'b1;
      @(posedge clk); #1;
    end
    got_valid = cost_valid_o;
    got_done  = done_o;
    cost      = int'(cost_o);
    bx        = int'(best_mv_x_o);
    by        = int'(best_mv_y_o);
    bcost     = int'(best_cost_o);
    pcyc      = cyc;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({cand_ready_o, busy_o, cost_valid_o, done_o} !== 4'b0) begin
      bad++; $display("FAIL reset_flags got=%b want=0000", {cand_ready_o, busy_o, cost_valid_o, done_o});
    end
    total++;
    if ({cost_o, best_cost_o, best_mv_x_o, best_mv_y_o} !== '0) begin
      bad++; $display("FAIL reset_data cost=%0d best_cost=%0d best=(%0d,%0d) want all 0",
                      cost_o, best_cost_o, best_mv_x_o, best_mv_y_o);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single;
    bit v, d, e, t; int c, bx, by, bc, pc;
    do_start(0, 0, 4);
    total++;
    if (best_cost_o !== 16'hFFFF || best_mv_x_o !== '0 || busy_o !== 1'b1) begin
      bad++; $display("FAIL start_init best_cost=%0h busy=%b want ffff/1", best_cost_o, busy_o);
    end
    send_cand(0, 0, 1'b1, v, c, d, bx, by, bc, pc, e, t);
    total++;
    if (t || e || v !== 1'b1 || d !== 1'b1) begin
      bad++; $display("FAIL single_pulses valid=%b done=%b early=%b timeout=%b want 1 1 0 0", v, d, e, t);
    end
    total++;
    if (c !== 8 || c !== ref_cost(4, 0, 0, 0, 0)) begin
      bad++; $display("FAIL single_cost got=%0d want=8", c);
    end
    total++;
    if (bx !== 0 || by !== 0 || bc !== 8) begin
      bad++; $display("FAIL single_best got=(%0d,%0d,%0d) want=(0,0,8)", bx, by, bc);
    end
    do_start(2, -3, 10);
    total++;
    if (cost_o !== 16'd8) begin
      bad++; $display("FAIL cost_hold_on_start got=%0d want=8", cost_o);
    end
    send_cand(5, -3, 1'b1, v, c, d, bx, by, bc, pc, e, t);
    total++;
    if (t || v !== 1'b1 || c !== 60) begin
      bad++; $display("FAIL mvp_offset_cost got=%0d valid=%b want=60", c, v);
    end
  endtask

  task automatic test_boundaries;
    int tbl [3][6] = '{'{0, 0, 1, 1023, -1024, 52},
                       '{2047, 0, 1, -2048, 0, 32},
                       '{0, 0, 255, 1024, 1024, 15810}};
    bit v, d, e, t; int c, bx, by, bc, pc;
    for (int i = 0; i < 3; i++) begin
      do_start(tbl[i][0], tbl[i][1], tbl[i][2]);
      send_cand(tbl[i][3], tbl[i][4], 1'b1, v, c, d, bx, by, bc, pc, e, t);
      total++;
      if (t || v !== 1'b1 || c !== tbl[i][5] || c !== ref_cost(tbl[i][2], tbl[i][0], tbl[i][1], tbl[i][3], tbl[i][4])) begin
        bad++; $display("FAIL boundary_%0d got=%0d want=%0d", i, c, tbl[i][5]);
      end
    end
  endtask

  task automatic test_list;
    int xs [3] = '{2, 3, 0};
    int ys [3] = '{2, 0, -2};
    int exp [3] = '{40, 24, 24};
    bit v, d, e, t; int c, bx, by, bc, pc, prev;
    prev = 0;
    do_start(0, 0, 4);
    for (int i = 0; i < 3; i++) begin
      send_cand(xs[i], ys[i], i == 2, v, c, d, bx, by, bc, pc, e, t);
      total++;
      if (t || v !== 1'b1 || c !== exp[i] || d !== (i == 2)) begin
        bad++; $display("FAIL list_cost_%0d got=%0d done=%b want=%0d done=%0d", i, c, d, exp[i], i == 2);
      end
      if (i > 0) begin
        total++;
        if (pc - prev !== 4) begin
          bad++; $display("FAIL list_spacing_%0d got=%0d want=4", i, pc - prev);
        end
      end
      prev = pc;
    end
    total++;
    if (bx !== 3 || by !== 0 || bc !== 24) begin
      bad++; $display("FAIL list_best got=(%0d,%0d,%0d) want=(3,0,24)", bx, by, bc);
    end
  endtask

  task automatic test_back_to_back;
    bit v, d, e, t; int c, bx, by, bc, pc;
    int lam, mx, my, len, cx, cy, ec, best, bmx, bmy;
    for (int l = 0; l < 20; l++) begin
      lam = int'($urandom_range(0, 255));
      mx  = int'($urandom_range(0, 4095)) - 2048;
      my  = int'($urandom_range(0, 60)) - 30;
      len = int'($urandom_range(1, 5));
      best = 65535; bmx = 0; bmy = 0;
      do_start(mx, my, lam);
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 3) == 0) begin
          cx = int'($urandom_range(0, 4095)) - 2048;
          cy = int'($urandom_range(0, 4095)) - 2048;
        end else begin
          cx = mx + int'($urandom_range(0, 80)) - 40;
          cy = my + int'($urandom_range(0, 80)) - 40;
          if (cx > 2047) cx = 2047;
          if (cx < -2048) cx = -2048;
        end
        ec = ref_cost(lam, mx, my, cx, cy);
        if (ec < best) begin best = ec; bmx = cx; bmy = cy; end
        send_cand(cx, cy, k == len - 1, v, c, d, bx, by, bc, pc, e, t);
        total++;
        if (t || e || v !== 1'b1 || c !== ec || d !== (k == len - 1)) begin
          bad++; $display("FAIL rand_cost l=%0d k=%0d got=%0d done=%b want=%0d", l, k, c, d, ec);
        end
      end
      total++;
      if (bx !== bmx || by !== bmy || bc !== best) begin
        bad++; $display("FAIL rand_best l=%0d got=(%0d,%0d,%0d) want=(%0d,%0d,%0d)",
                        l, bx, by, bc, bmx, bmy, best);
      end
    end
  endtask

  task automatic test_backpressure;
    int ec;
    bit er, ev, ed, eb;
    ec = ref_cost(7, 1, 1, 9, -4);
    do_start(1, 1, 7);
    cand_valid_i = 1'b1;
    cand_mv_x_i  = MVW'(9);
    cand_mv_y_i  = MVW'(-4);
    cand_last_i  = 1'b0;
    for (int k = 0; k < 14; k++) begin
      er = (k % 4 == 0) && (k < 12);
      ev = (k == 4) || (k == 8) || (k == 12);
      ed = (k == 12);
      eb = (k < 12);
      total++;
      if ({cand_ready_o, cost_valid_o, done_o, busy_o} !== {er, ev, ed, eb}) begin
        bad++; $display("FAIL bp_flags k=%0d got rdy/val/done/busy=%b want=%b",
                        k, {cand_ready_o, cost_valid_o, done_o, busy_o}, {er, ev, ed, eb});
      end
      if (ev) begin
        total++;
        if (cost_o !== CW'(ec)) begin
          bad++; $display("FAIL bp_cost k=%0d got=%0d want=%0d", k, cost_o, ec);
        end
      end
      start_i = (k == 2);
      if (k == 2) begin
        lambda_i = 8'd200;
        mvp_x_i  = '0;
        mvp_y_i  = '0;
      end
      if (k == 8) cand_last_i = 1'b1;
      @(posedge clk); #1;
    end
    start_i = 1'b0;
    cand_valid_i = 1'b0;
    cand_last_i = 1'b0;
    total++;
    if (best_mv_x_o !== 12'sd9 || best_mv_y_o !== -12'sd4 || best_cost_o !== CW'(ec)) begin
      bad++; $display("FAIL bp_best got=(%0d,%0d,%0d) want=(9,-4,%0d)",
                      best_mv_x_o, best_mv_y_o, best_cost_o, ec);
    end
  endtask

  task automatic test_reset_mid;
    bit v, d, e, t; int c, bx, by, bc, pc;
    do_start(3, 3, 5);
    cand_valid_i = 1'b1;
    cand_mv_x_i  = MVW'(10);
    cand_mv_y_i  = MVW'(10);
    cand_last_i  = 1'b1;
    @(posedge clk); #1;
    cand_valid_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++;
    if ({cand_ready_o, busy_o, cost_valid_o, done_o} !== 4'b0 ||
        {cost_o, best_cost_o, best_mv_x_o, best_mv_y_o} !== '0) begin
      bad++; $display("FAIL midreset_clear flags=%b cost=%0d best_cost=%0d want 0",
                      {cand_ready_o, busy_o, cost_valid_o, done_o}, cost_o, best_cost_o);
    end
    cand_valid_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      total++;
      if ({cand_ready_o, busy_o, cost_valid_o, done_o} !== 4'b0) begin
        bad++; $display("FAIL midreset_idle k=%0d got=%b want=0000", k,
                        {cand_ready_o, busy_o, cost_valid_o, done_o});
      end
    end
    cand_valid_i = 1'b0;
    cand_last_i  = 1'b0;
    do_start(-5, 7, 3);
    send_cand(-1, 0, 1'b1, v, c, d, bx, by, bc, pc, e, t);
    total++;
    if (t || v !== 1'b1 || d !== 1'b1 || c !== ref_cost(3, -5, 7, -1, 0)) begin
      bad++; $display("FAIL after_reset_cost got=%0d want=%0d", c, ref_cost(3, -5, 7, -1, 0));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_boundaries();
    test_list();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fme_mvd_cost_ctrl.md
Name: fme_mvd_cost_ctrl

Overview:
- Sequences a motion-vector-difference rate estimate for each FME candidate MV and tracks the lowest-cost candidate of a list.
- Accepts candidates one at a time against a latched MV predictor and lambda.
- Time-shares one internal combinational bit-length unit between the x and y MVD components.
- Returns a per-candidate cost plus the best MV and cost when the list ends.

Parameters:
- MV_WIDTH, 12: signed MV/MVP component width, quarter-pel units.
- LAMBDA_WIDTH, 8: unsigned lambda width.
- COST_WIDTH, 16: unsigned cost width; results saturate to this width.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous active-high reset.
- start_i, input, 1: latches mvp_x_i, mvp_y_i and lambda_i; accepted only in IDLE.
- mvp_x_i, input, MV_WIDTH: predictor x, signed.
- mvp_y_i, input, MV_WIDTH: predictor y, signed.
- lambda_i, input, LAMBDA_WIDTH: rate weight.
- cand_valid_i, input, 1: candidate present.
- cand_ready_o, output, 1: controller can accept a candidate.
- cand_mv_x_i, input, MV_WIDTH: candidate x, signed.
- cand_mv_y_i, input, MV_WIDTH: candidate y, signed.
- cand_last_i, input, 1: marks the final candidate of the list.
- busy_o, output, 1: high in every state except IDLE.
- cost_valid_o, output, 1: one-cycle pulse; cost_o is valid.
- cost_o, output, COST_WIDTH: cost of the most recent candidate.
- done_o, output, 1: one-cycle pulse; best_* outputs are final.
- best_mv_x_o, output, MV_WIDTH: best candidate x.
- best_mv_y_o, output, MV_WIDTH: best candidate y.
- best_cost_o, output, COST_WIDTH: best cost.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset: all outputs 0, state IDLE, latched MVP/lambda 0. Reset asserted mid-operation aborts the list; no cost_valid_o or done_o is produced for it.
- Outputs are registered.
- FSM states: IDLE, WAIT, CALC_X, CALC_Y, COST.
  - IDLE: start_i -> WAIT. On that edge: latch MVP and lambda, best_cost <= all ones, best_mv <= 0.
  - WAIT: cand_ready_o = 1. cand_valid_i && cand_ready_o -> register the candidate and its last flag, go to CALC_X.
  - CALC_X: d = cand_x - mvp_x, computed in MV_WIDTH+1 signed bits. v = |d|, clamped to 2047. bits_x <= BL(v). Go to CALC_Y.
  - CALC_Y: same for y into bits_y. Go to COST.
  - COST: prod = lambda * (bits_x + bits_y). cost_o <= min(prod, 2^COST_WIDTH-1). cost_valid_o <= 1.
    - If cost < best_cost (strict; a tie keeps the earlier candidate): update best_cost/best_mv.
    - If last: done_o <= 1 with the updated best_* values, go to IDLE. Otherwise go to WAIT.
- cand_ready_o is 0 in IDLE, CALC_X, CALC_Y and COST. start_i is ignored outside IDLE. cand_valid_i is ignored outside WAIT.
- Latency: acceptance edge t0; cost_valid_o (and done_o if last) high during cycle t0+3 only. Throughput: one candidate per 4 cycles.
- On the final candidate, cost_valid_o and done_o pulse in the same cycle.
- best_*, cost_o and latched values hold until overwritten. Outputs are not cleared on start.
- BL(v), the bit-length function (odd Exp-Golomb length, saturated):
  - v=0 -> 1; v=1 -> 3; v=2..3 -> 5; v=4..7 -> 7; v=8..15 -> 9; v=16..31 -> 11.
  - v=32..63 -> 13; v=64..127 -> 15; v=128..255 -> 17; v=256..511 -> 19; v=512..1023 -> 21.
  - v>=1024 -> 31.
- Widths: bits per component 5b. The sum is 6b (max 62). The product is LAMBDA_WIDTH+6 bits before saturation.

Test Plan:
- start with mvp=(0,0), lambda=4; one candidate (0,0), last=1 -> cost_valid_o and done_o together at t0+3: cost_o=8, best=(0,0), cost 8.
- mvp=(2,-3), lambda=10; candidate (5,-3) -> dx=3 gives 5, dy=0 gives 1, cost_o=60.
- Boundaries with lambda=1, mvp=(0,0):
  - candidate (1023,-1024) -> 21+31=52.
  - candidate (-2048,0) with mvp=(2047,0) -> |d|=4095 clamped -> 31+1=32.
  - lambda=255, candidate (1024,1024) -> 15810.
- List of 3 candidates giving costs 40, 24, 24 -> three cost_valid_o pulses 4 cycles apart; done_o with the second candidate's MV and best_cost_o=24.
- Back-pressure: cand_valid_i held high throughout -> accepted only in WAIT, cand_ready_o low for 3 cycles after each accept. start_i pulsed in CALC_Y -> ignored, latched lambda unchanged.
- rst asserted for one cycle during CALC_Y -> next cycle all outputs 0, busy_o=0, no cost_valid_o. cand_valid_i is ignored until a new start_i.
